apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_master_pkg.sv | 18 +
 rtl/apb_req_master.sv | 122 ++++++++++++
 tb/tb_apb_req_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB request master.
//   state_e   : transfer state encoding (IDLE / SETUP / ACCESS)
//   cnt_width : bit width needed to count up to a given wait-cycle limit
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // At least one bit, so a disabled timeout (limit 0) still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit < 2) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_req_master.sv
// APB master bridging a simple req/gnt initiator port onto an APB bus.
// One transfer outstanding at a time; optional ACCESS-phase wait timeout.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   req_i, we_i, addr_i, wdata_i  local request (sampled when gnt_o=1)
//   gnt_o                         combinational grant, only in IDLE
//   rvalid_o, rdata_o, err_o      one-cycle completion with read data / error
//   busy_o                        transfer in SETUP or ACCESS
//   PADDR, PWDATA, PWRITE,
//   PSEL, PENABLE                 APB master outputs
//   PRDATA, PREADY, PSLVERR       APB slave responses
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned CW     = cnt_width(TIMEOUT_CYCLES);
  // Abort on the ACCESS cycle whose PREADY=0 would bring the count to the limit.
  localparam int unsigned TO_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        TO_EN  = (TIMEOUT_CYCLES != 0);

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          done;
  logic          timeout;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, grant, completion and wait-counter logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnt_o   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          // Ready wins over a simultaneous limit hit.
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (TO_EN && (cnt == CW'(TO_LIM))) begin
          done    = 1'b1;
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered APB and completion outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      busy_o   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PWRITE   <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      PSEL     <= (state_d != ST_IDLE);
      PENABLE  <= (state_d == ST_ACCESS);
      busy_o   <= (state_d != ST_IDLE);
      rvalid_o <= done;
      if (gnt_o) begin
        PADDR  <= addr_i;
        PWDATA <= wdata_i;
        PWRITE <= we_i;
      end
      if (done) begin
        rdata_o <= (timeout || PWRITE) ? 32'h0 : PRDATA;
        err_o   <= timeout | PSLVERR;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed testbench for apb_req_master: per-cycle vector table plus a
// hand-written reset-during-ACCESS sequence.
module tb_apb_req_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_i, we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int errors = 0;
  int checks = 0;

  apb_req_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .busy_o(busy_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        gnt, psel, pen, busy, rv, err, pwrite;
    logic [31:0] rdata;
    logic [11:0] paddr;
    logic [31:0] pwdata;
  } outs_t;

  typedef struct {
    logic        req, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic outs_t sample();
    outs_t o;
    o = '{gnt: gnt_o, psel: PSEL, pen: PENABLE, busy: busy_o, rv: rvalid_o,
          err: err_o, pwrite: PWRITE, rdata: rdata_o, paddr: PADDR, pwdata: PWDATA};
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Inputs for one cycle, then the outputs expected in that same cycle.
  task automatic add(input logic req, input logic we, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic pready,
                     input logic [31:0] prdata, input logic pslverr,
                     input logic gnt, input logic psel, input logic pen,
                     input logic rv, input logic err, input logic [31:0] rdata,
                     input logic [11:0] paddr, input logic [31:0] pwdata,
                     input logic pwrite);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.pready = pready; v.prdata = prdata; v.pslverr = pslverr;
    v.exp = '{gnt: gnt, psel: psel, pen: pen, busy: psel, rv: rv, err: err,
              pwrite: pwrite, rdata: rdata, paddr: paddr, pwdata: pwdata};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic we, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic pready,
                       input logic [31:0] prdata, input logic pslverr);
    req_i = req; we_i = we; addr_i = addr; wdata_i = wdata;
    PREADY = pready; PRDATA = prdata; PSLVERR = pslverr;
  endtask

  initial begin
    //   req we addr    wdata        rdy prdata       serr gnt sel en rv err rdata        paddr   pwdata       pw
    // Zero-wait write
    add(1, 1, 12'h004, 32'hDEADBEEF, 0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h0,        12'h000, 32'h0,        0); // c0
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        12'h004, 32'hDEADBEEF, 1); // c1
    add(0, 0, 12'h000, 32'h0,        1, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h004, 32'hDEADBEEF, 1); // c2
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 0, 32'h0,        12'h004, 32'hDEADBEEF, 1); // c3
    // Read, 3 wait states (ready on 4th ACCESS cycle = timeout limit cycle)
    add(1, 0, 12'h010, 32'h0,        0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h0,        12'h004, 32'hDEADBEEF, 1); // c4
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        12'h010, 32'h0,        0); // c5
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h010, 32'h0,        0); // c6
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h010, 32'h0,        0); // c7
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h010, 32'h0,        0); // c8
    add(0, 0, 12'h000, 32'h0,        1, 32'h12345678, 0,   0, 1, 1, 0, 0, 32'h0,        12'h010, 32'h0,        0); // c9
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 0, 32'h12345678, 12'h010, 32'h0,        0); // c10
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h12345678, 12'h010, 32'h0,        0); // c11
    // Slave error on write
    add(1, 1, 12'h020, 32'h1,        0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h12345678, 12'h010, 32'h0,        0); // c12
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h12345678, 12'h020, 32'h1,        1); // c13
    add(0, 0, 12'h000, 32'h0,        1, 32'hFFFFFFFF, 1,   0, 1, 1, 0, 0, 32'h12345678, 12'h020, 32'h1,        1); // c14
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 1, 32'h0,        12'h020, 32'h1,        1); // c15
    // Timeout: PREADY held low, abort after 4 ACCESS cycles
    add(1, 0, 12'h030, 32'h0,        0, 32'h0,        0,   1, 0, 0, 0, 1, 32'h0,        12'h020, 32'h1,        1); // c16
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 0, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c17
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c18
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c19
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 1, 1, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c20
    add(0, 0, 12'h000, 32'h0,        0, 32'hAAAAAAAA, 0,   0, 1, 1, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c21
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 1, 32'h0,        12'h030, 32'h0,        0); // c22
    // Back-to-back writes, req held, zero wait
    add(1, 1, 12'h040, 32'hA0,       1, 32'h0,        0,   1, 0, 0, 0, 1, 32'h0,        12'h030, 32'h0,        0); // c23
    add(1, 1, 12'h044, 32'hA4,       1, 32'h0,        0,   0, 1, 0, 0, 1, 32'h0,        12'h040, 32'hA0,       1); // c24
    add(1, 1, 12'h044, 32'hA4,       1, 32'h0,        0,   0, 1, 1, 0, 1, 32'h0,        12'h040, 32'hA0,       1); // c25
    add(1, 1, 12'h044, 32'hA4,       1, 32'h0,        0,   1, 0, 0, 1, 0, 32'h0,        12'h040, 32'hA0,       1); // c26
    add(1, 1, 12'h048, 32'hA8,       1, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        12'h044, 32'hA4,       1); // c27
    add(1, 1, 12'h048, 32'hA8,       1, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h044, 32'hA4,       1); // c28
    add(1, 1, 12'h048, 32'hA8,       1, 32'h0,        0,   1, 0, 0, 1, 0, 32'h0,        12'h044, 32'hA4,       1); // c29
    add(0, 0, 12'h000, 32'h0,        1, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        12'h048, 32'hA8,       1); // c30
    add(0, 0, 12'h000, 32'h0,        1, 32'h0,        0,   0, 1, 1, 0, 0, 32'h0,        12'h048, 32'hA8,       1); // c31
    add(0, 0, 12'h000, 32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 0, 32'h0,        12'h048, 32'hA8,       1); // c32

    // Reset
    HRESETn = 1'b0;
    drive(0, 0, 12'h0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(negedge HCLK);
    #1 check("reset_state", sample(), outs_t'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Vector table: drive at negedge, check just after
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge HCLK);
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].pready, vecs[i].prdata, vecs[i].pslverr);
      #1 check($sformatf("vec_c%0d", i), sample(), vecs[i].exp);
    end

    // Reset while in ACCESS
    @(negedge HCLK);
    drive(1, 0, 12'h0AB, 32'h55, 0, 32'h0, 0);
    @(negedge HCLK);
    drive(0, 0, 12'h0, 32'h0, 0, 32'h0, 0);
    @(negedge HCLK);
    #1 check_bit("mid_access_penable", PENABLE, 1'b1);
    #2 HRESETn = 1'b0;
    #1 check("reset_in_access", sample(), outs_t'(0));
    @(negedge HCLK);
    drive(0, 0, 12'h0, 32'h0, 1, 32'hCAFEF00D, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      #1 check_bit($sformatf("no_rvalid_after_reset_%0d", i), rvalid_o, 1'b0);
      check_bit($sformatf("no_psel_after_reset_%0d", i), PSEL, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
